// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock timekeeping core.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    // 1 MHz system clock divided down to a 100 Hz tick.
    localparam int DIV_DEFAULT = 10000;

    // Decimal points: HH.MM.SS.cc while running; a single blinking dot while setting.
    localparam logic [7:0] DOT_RUN     = 8'b0101_0100;
    localparam int         DOT_HR_BIT  = 6;
    localparam int         DOT_MIN_BIT = 4;

    // Field moduli for hundredths, seconds, minutes, hours.
    localparam int MOD_CC = 100;
    localparam int MOD_SS = 60;
    localparam int MOD_MM = 60;
    localparam int MOD_HH = 24;

    // Ticks between blink toggles in the set states.
    localparam int BLINK_PERIOD = 50;

    // Decimal-point pattern for a given state and blink phase.
    function automatic logic [7:0] dot_for(input state_t s, input logic blink);
        logic [7:0] d;
        d = 8'b0;
        case (s)
            RUN:     d = DOT_RUN;
            SET_HR:  d[DOT_HR_BIT] = blink;
            SET_MIN: d[DOT_MIN_BIT] = blink;
            default: d = DOT_RUN;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/clock_counter_bcd2_cnt.sv
// Two-digit BCD modulo counter: counts 00..MOD-1, carry is high when an
// enabled count wraps back to 00. Clear has priority over enable.
module bcd2_cnt #(
    parameter int MOD = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
    localparam logic [3:0] MAX_O = 4'((MOD - 1) % 10);

    logic at_max;

    // Terminal value detect and ripple carry for the next field up.
    always_comb begin
        at_max = (tens == MAX_T) && (ones == MAX_O);
        carry  = en && at_max;
    end

    // Digit registers: wrap at MOD-1, otherwise ones 0..9 with tens carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (en) begin
            if (at_max) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_counter.sv
// Timekeeping core: 100 Hz prescaler, debounced keys, set-mode FSM and the
// HH.MM.SS.cc BCD time chain. dbg_state exposes the FSM; dbg_rollover is the
// hours carry (high in the tick cycle where 23:59:59.99 wraps to midnight).
module clock_counter
    import clock_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic       CP_1MHz,
    input  logic       nCLR,
    input  logic       iMode,
    input  logic       iInc,
    output logic [3:0] D7,
    output logic [3:0] D6,
    output logic [3:0] D5,
    output logic [3:0] D4,
    output logic [3:0] D3,
    output logic [3:0] D2,
    output logic [3:0] D1,
    output logic [3:0] D0,
    output logic [7:0] DOT,
    output logic       oTick,
    output logic [1:0] dbg_state,
    output logic       dbg_rollover
);

    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt, cnt_next;
    logic          tick_q;
    logic          mode_s1, mode_s2, mode_prev;
    logic          inc_s1, inc_s2, inc_prev;
    logic          mode_p, inc_p;
    state_t        state, state_next;
    logic          blink, blink_next;
    logic [5:0]    blink_cnt, blink_cnt_next;
    logic          restart, clr_sec;
    logic          run;
    logic          cc_en, mm_en, hh_en;
    logic          cc_carry, ss_carry, mm_carry, hh_carry;

    // Prescaler next value; leaving set mode restarts the count from zero.
    always_comb begin
        if (restart || cnt == CNT_MAX) cnt_next = '0;
        else                           cnt_next = cnt + CW'(1);
    end

    // Prescaler register and registered tick strobe (high while cnt == DIV-1).
    always_ff @(posedge CP_1MHz or negedge nCLR) begin
        if (!nCLR) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            tick_q <= (cnt_next == CNT_MAX);
        end
    end

    // Key synchronizers; the previous sample only moves on a tick (10 ms debounce).
    always_ff @(posedge CP_1MHz or negedge nCLR) begin
        if (!nCLR) begin
            mode_s1   <= 1'b0;
            mode_s2   <= 1'b0;
            mode_prev <= 1'b0;
            inc_s1    <= 1'b0;
            inc_s2    <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_s1 <= iMode;
            mode_s2 <= mode_s1;
            inc_s1  <= iInc;
            inc_s2  <= inc_s1;
            if (tick_q) begin
                mode_prev <= mode_s2;
                inc_prev  <= inc_s2;
            end
        end
    end

    // Rising-edge pulses at tick time; a mode pulse masks a coincident inc pulse.
    always_comb begin
        mode_p = tick_q && mode_s2 && !mode_prev;
        inc_p  = tick_q && inc_s2 && !inc_prev && !mode_p;
    end

    // FSM next state, blink phase and side effects of mode transitions.
    always_comb begin
        state_next     = state;
        blink_next     = blink;
        blink_cnt_next = blink_cnt;
        restart        = 1'b0;
        clr_sec        = 1'b0;
        case (state)
            RUN: begin
                if (mode_p) begin
                    state_next     = SET_HR;
                    blink_next     = 1'b1;
                    blink_cnt_next = 6'd0;
                    clr_sec        = 1'b1;
                end
            end
            SET_HR, SET_MIN: begin
                if (mode_p) begin
                    state_next     = (state == SET_HR) ? SET_MIN : RUN;
                    blink_next     = 1'b1;
                    blink_cnt_next = 6'd0;
                    restart        = (state == SET_MIN);
                end else if (tick_q) begin
                    if (blink_cnt == 6'(BLINK_PERIOD - 1)) begin
                        blink_cnt_next = 6'd0;
                        blink_next     = !blink;
                    end else begin
                        blink_cnt_next = blink_cnt + 6'd1;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    // FSM, blink and registered decimal points.
    always_ff @(posedge CP_1MHz or negedge nCLR) begin
        if (!nCLR) begin
            state     <= RUN;
            blink     <= 1'b1;
            blink_cnt <= 6'd0;
            DOT       <= DOT_RUN;
        end else begin
            state     <= state_next;
            blink     <= blink_next;
            blink_cnt <= blink_cnt_next;
            DOT       <= dot_for(state_next, blink_next);
        end
    end

    // Field enables: ripple chain while running, inc pulse drives HH/MM in set mode.
    always_comb begin
        run   = (state == RUN);
        cc_en = run && tick_q && !mode_p;
        mm_en = run ? ss_carry : ((state == SET_MIN) && inc_p);
        hh_en = run ? mm_carry : ((state == SET_HR) && inc_p);
    end

    bcd2_cnt #(.MOD(MOD_CC)) u_cc (
        .clk(CP_1MHz), .rst_n(nCLR), .en(cc_en), .clr(clr_sec),
        .tens(D1), .ones(D0), .carry(cc_carry)
    );

    bcd2_cnt #(.MOD(MOD_SS)) u_ss (
        .clk(CP_1MHz), .rst_n(nCLR), .en(cc_carry), .clr(clr_sec),
        .tens(D3), .ones(D2), .carry(ss_carry)
    );

    bcd2_cnt #(.MOD(MOD_MM)) u_mm (
        .clk(CP_1MHz), .rst_n(nCLR), .en(mm_en), .clr(1'b0),
        .tens(D5), .ones(D4), .carry(mm_carry)
    );

    bcd2_cnt #(.MOD(MOD_HH)) u_hh (
        .clk(CP_1MHz), .rst_n(nCLR), .en(hh_en), .clr(1'b0),
        .tens(D7), .ones(D6), .carry(hh_carry)
    );

    assign oTick        = tick_q;
    assign dbg_state    = state;
    assign dbg_rollover = run && hh_carry;

endmodule

// File: tb/tb_clock_counter.sv
// Self-checking bench for clock_counter with DIV=4: an integer time-of-day
// model checked every cycle, plus directed literal checkpoints.
module tb_clock_counter;

    localparam int DIV = 4;
    localparam int DAY = 8640000;

    logic       clk = 1'b0;
    logic       nclr = 1'b0;
    logic       imode = 1'b0;
    logic       iinc = 1'b0;
    logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0;
    logic [7:0] dot;
    logic       otick;
    logic [1:0] dbg_state;
    logic       dbg_rollover;

    int checks = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    clock_counter #(.DIV(DIV)) dut (
        .CP_1MHz(clk), .nCLR(nclr), .iMode(imode), .iInc(iinc),
        .D7(d7), .D6(d6), .D5(d5), .D4(d4), .D3(d3), .D2(d2), .D1(d1), .D0(d0),
        .DOT(dot), .oTick(otick), .dbg_state(dbg_state), .dbg_rollover(dbg_rollover)
    );

    function automatic logic [31:0] digits();
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int m_t;      // centiseconds since midnight
    int m_state;  // 0 run, 1 set hours, 2 set minutes
    int m_since;  // ticks since entering the current set state
    int m_cnt;    // prescaler position
    bit ms1, ms2, is1, is2, mprev, iprev;

    function automatic logic [31:0] time_bcd(input int t);
        int hh, mm, ss, cc;
        hh = t / 360000;
        mm = (t / 6000) % 60;
        ss = (t / 100) % 60;
        cc = t % 100;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [7:0] model_dot();
        bit b;
        b = ((m_since / 50) % 2) == 0;
        if (m_state == 1) return b ? 8'h40 : 8'h00;
        if (m_state == 2) return b ? 8'h10 : 8'h00;
        return 8'h54;
    endfunction

    task automatic model_reset();
        m_t = 0; m_state = 0; m_since = 0; m_cnt = 0;
        ms1 = 0; ms2 = 0; is1 = 0; is2 = 0; mprev = 0; iprev = 0;
    endtask

    task automatic model_step();
        bit tick, mp, ip;
        int hh, mm;
        tick = (m_cnt == DIV - 1);
        mp = tick && ms2 && !mprev;
        ip = tick && is2 && !iprev && !mp;
        if (tick) begin
            mprev = ms2;
            iprev = is2;
        end
        ms2 = ms1; ms1 = imode;
        is2 = is1; is1 = iinc;
        if (mp && m_state == 2) m_cnt = 0;
        else                    m_cnt = (m_cnt + 1) % DIV;
        if (tick) begin
            if (mp) begin
                if (m_state == 0) m_t = m_t - (m_t % 6000);
                m_state = (m_state + 1) % 3;
                m_since = 0;
            end else if (m_state == 0) begin
                m_t = (m_t + 1) % DAY;
            end else begin
                m_since++;
                if (ip && m_state == 1) begin
                    hh = m_t / 360000;
                    m_t = (m_t % 360000) + ((hh + 1) % 24) * 360000;
                end
                if (ip && m_state == 2) begin
                    mm = (m_t / 6000) % 60;
                    m_t = m_t + (((mm + 1) % 60) - mm) * 6000;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge nclr);
            if (!nclr) model_reset();
            else       model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (nclr)
                check("cycle_outputs",
                      {21'd0, digits(), dot, otick, dbg_state},
                      {21'd0, time_bcd(m_t), model_dot(), 1'(m_cnt == DIV - 1), 2'(m_state)});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (otick !== 1'b1 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (otick !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout actual=no_tick required=tick within %0d cycles", 4 * DIV);
        end
    endtask

    task automatic ticks(input int k);
        repeat (k) wait_tick();
    endtask

    task automatic press(input bit m, input bit i);
        imode = m;
        iinc  = i;
        ticks(2);
        imode = 1'b0;
        iinc  = 1'b0;
        ticks(2);
    endtask

    // Hold mode until the FSM reports RUN (bounded); returns at that negedge.
    task automatic mode_to_run();
        int n;
        n = 0;
        imode = 1'b1;
        @(negedge clk);
        while (dbg_state !== 2'd0 && n < 8 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("to_run_state", 64'(dbg_state), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_digits", 64'(digits()), 64'h0);
        check("reset_dot", 64'(dot), 64'h54);
        check("reset_otick", 64'(otick), 64'h0);
        check("reset_state", 64'(dbg_state), 64'h0);
        nclr = 1'b1;

        // Carry chain from midnight.
        ticks(100);
        @(negedge clk);
        check("carry_1s", 64'(digits()), 64'h0000_0100);
        ticks(5900);
        @(negedge clk);
        check("carry_1min", 64'(digits()), 64'h0001_0000);

        // Asynchronous reset away from any clock edge.
        @(posedge clk);
        #3 nclr = 1'b0;
        #1;
        check("async_rst_digits", 64'(digits()), 64'h0);
        check("async_rst_dot", 64'(dot), 64'h54);
        check("async_rst_otick", 64'(otick), 64'h0);
        check("async_rst_state", 64'(dbg_state), 64'h0);
        @(negedge clk);
        nclr = 1'b1;

        // Set hours.
        ticks(150);
        @(negedge clk);
        check("pre_set_time", 64'(digits()), 64'h0000_0150);
        press(1'b1, 1'b0);
        check("enter_set_hr", 64'(dbg_state), 64'd1);
        check("set_hr_clear", 64'(digits()), 64'h0);
        check("set_hr_dot", 64'(dot), 64'h40);
        repeat (25) press(1'b0, 1'b1);
        check("hh_25_inc", 64'(digits()), 64'h0100_0000);

        // Set minutes.
        press(1'b1, 1'b0);
        check("enter_set_min", 64'(dbg_state), 64'd2);
        repeat (61) press(1'b0, 1'b1);
        check("mm_61_inc", 64'(digits()), 64'h0101_0000);

        // Back to run: first advance DIV cycles after the transition.
        mode_to_run();
        imode = 1'b0;
        n = 0;
        while (d0 !== 4'd1 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("restart_latency", 64'(n), 64'(DIV));
        ticks(2);

        // Mode and inc together: mode wins.
        press(1'b1, 1'b1);
        check("simul_state", 64'(dbg_state), 64'd1);
        check("simul_no_inc", 64'(digits()), 64'h0101_0000);

        // One-cycle inc glitch between ticks.
        wait_tick();
        @(negedge clk);
        iinc = 1'b1;
        @(negedge clk);
        iinc = 1'b0;
        ticks(3);
        check("glitch_ignored", 64'(digits()), 64'h0101_0000);

        // Inc held for ten ticks.
        iinc = 1'b1;
        ticks(10);
        iinc = 1'b0;
        ticks(2);
        check("held_one_inc", 64'(digits()), 64'h0201_0000);

        // Preload 23:59 and run into the day rollover.
        repeat (21) press(1'b0, 1'b1);
        check("hh_wrap_to_23", 64'(digits()), 64'h2301_0000);
        press(1'b1, 1'b0);
        repeat (58) press(1'b0, 1'b1);
        check("mm_to_59", 64'(digits()), 64'h2359_0000);
        mode_to_run();
        imode = 1'b0;
        ticks(5999);
        @(negedge clk);
        check("pre_rollover", 64'(digits()), 64'h2359_5999);
        wait_tick();
        check("rollover_carry", 64'(dbg_rollover), 64'd1);
        @(negedge clk);
        check("rollover", 64'(digits()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog.
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish before 2ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clock_counter.md
# clock_counter

Timekeeping core of the digital clock: divides the 1 MHz system clock down to a 100 Hz tick and keeps time as eight BCD digits, HH.MM.SS.cc. It also runs a small key-driven set-mode state machine for adjusting hours and minutes. It sits directly upstream of the display path: each digit output feeds one SEG7_LUT, and DOT feeds the display multiplexer's decimal-point input.

## Interface
- DIV, default 10000: CP_1MHz cycles per 100 Hz tick, must be ≥ 2 (benches use small values).
- CP_1MHz  in  1  system clock; all logic is clocked on its rising edge.
- nCLR  in  1  reset, asynchronous and active-low.
- iMode  in  1  mode key, raw level, active-high.
- iInc  in  1  increment key, raw level, active-high.
- D7..D0  out  4 each  BCD digits: D7/D6 hours tens/ones, D5/D4 minutes, D3/D2 seconds, D1/D0 hundredths.
- DOT  out  8  decimal points; bit 7 is the D7 position.
- oTick  out  1  one-cycle strobe on each 100 Hz tick.

## Operation
- **Prescaler**
  - Counter runs 0..DIV-1 and wraps to 0.
  - oTick = 1 in the cycle where count == DIV-1.
- **Keys**
  - Both keys go through a 2-FF synchronizer.
  - The synchronized level is sampled only on oTick, which gives 10 ms debounce.
  - A pulse is produced when the sampled value is 1 and the previous sample was 0.
- **FSM states:** RUN, SET_HR, SET_MIN.
  - Mode pulse moves RUN→SET_HR, SET_HR→SET_MIN, SET_MIN→RUN.
- **RUN**
  - The time chain advances on each oTick: cc 00..99 → SS 00..59 → MM 00..59 → HH 00..23.
  - Carries ripple combinationally in the same tick.
  - 23:59:59.99 rolls to 00:00:00.00.
- **Entering SET_HR:** SS and cc are cleared to 00, and the time is frozen.
- **SET_HR:** an inc pulse adds 1 to HH modulo 24 (23→00), with no carry into any other field.
- **SET_MIN:** an inc pulse adds 1 to MM modulo 60 (59→00), with no carry into HH.
- **SET_MIN→RUN:** the prescaler restarts at 0, so the first advance comes DIV cycles later.
- **DOT**
  - RUN: 8'b0101_0100.
  - SET_HR: bit 6 = blink, all other bits 0.
  - SET_MIN: bit 4 = blink, all other bits 0.
  - blink toggles every 50 ticks and is reset to 1 on entry to each SET state.
- **BCD rules**
  - Every digit stays in 0..9.
  - Tens digits never exceed 9, 5, 5, 2 for cc, SS, MM, HH respectively.
  - HH ones wraps at 3 when HH tens = 2.

## Timing
- **Reset (asynchronous, immediate):**
  - all digits 0, state RUN, prescaler 0, oTick 0;
  - DOT 8'b0101_0100, blink 1;
  - synchronizers and previous-sample registers 0.
- **Output timing**
  - All outputs are registered.
  - Digits update in the cycle after oTick.
  - Key-to-effect latency: 2 sync cycles plus up to DIV cycles to the next tick, plus 1 cycle.
- **Simultaneous events**
  - Mode and inc pulses on the same tick: mode wins and inc is ignored.
  - A mode pulse on a RUN tick suppresses that tick's time advance.
  - Inc in RUN is ignored.
- **Reset mid-operation:** nCLR low in any state returns to RUN at 00:00:00.00 with no partial-update residue.
- **Key held:** produces one pulse only; no auto-repeat.

## Structure
- **Package clock_pkg holds:**
  - state enum (RUN, SET_HR, SET_MIN);
  - DIV default;
  - DOT constants (DOT_RUN = 8'b0101_0100, SET_HR bit index 6, SET_MIN bit index 4);
  - field moduli 100/60/60/24;
  - blink period 50.
- **Sub-module bcd2_cnt**
  - Two-digit BCD modulo counter with enable, clear, carry-out, and a modulus parameter.
  - Instantiated four times: cc, SS, MM, HH.
  - In SET states the HH and MM instances are enabled by the inc pulse, with carry ignored.

## Test plan
All scenarios use DIV=4.
- **Reset:** assert nCLR mid-count → all digits 0, DOT=8'b0101_0100, oTick=0 immediately, without waiting for a clock edge.
- **Rollover:** preload to 23:59:59.99 via set mode plus run, then one tick → 00:00:00.00.
- **Carry chain:** 100 ticks from 00:00:00.00 → 00:00:01.00; 6000 ticks → 00:01:00.00.
- **Set hours:** mode pulse, then 25 inc pulses → state SET_HR, HH=01, SS=cc=00, DOT bit 6 toggles every 50 ticks, other fields frozen.
- **Set minutes:** mode pulse ×2, then 61 inc pulses → MM=01, HH unchanged.
  - A third mode pulse → RUN, first advance exactly DIV cycles later.
- **Simultaneous/bounce:**
  - iMode and iInc rising in the same tick window → state advances, no increment.
  - iInc glitch shorter than DIV cycles between ticks → no pulse.
  - iInc held 10 ticks → exactly one increment.
